// File: rtl/terminal_scroll_controller_if.sv
// Request and grid-write bundle between the input buffer, the scroll controller
// and the character-grid RAM.
interface terminal_scroll_controller_if #(
    parameter int SCREEN_WIDTH  = 76,
    parameter int SCREEN_HEIGHT = 44
);
    localparam int AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam int CW = $clog2(SCREEN_WIDTH);
    localparam int RW = $clog2(SCREEN_HEIGHT);

    logic          char_valid_in;
    logic [7:0]    char_in;
    logic          enter_in;
    logic          bksp_in;
    logic          new_frame_in;
    logic          ready_out;
    logic          tg_we;
    logic [AW-1:0] tg_addr;
    logic [7:0]    tg_input;
    logic [CW-1:0] cursor_col_out;
    logic [RW-1:0] cursor_row_out;
    logic [RW-1:0] scroll_row_out;
    logic          cursor_on_out;

    modport master (
        output char_valid_in, char_in, enter_in, bksp_in, new_frame_in,
        input  ready_out, tg_we, tg_addr, tg_input,
        input  cursor_col_out, cursor_row_out, scroll_row_out, cursor_on_out
    );

    modport slave (
        input  char_valid_in, char_in, enter_in, bksp_in, new_frame_in,
        output ready_out, tg_we, tg_addr, tg_input,
        output cursor_col_out, cursor_row_out, scroll_row_out, cursor_on_out
    );
endinterface

// File: rtl/terminal_scroll_controller.sv
// Turns character/enter/backspace events into character-grid RAM writes, with
// line wrap, circular-offset hardware scroll, row/screen clearing and cursor blink.
module terminal_scroll_controller #(
    parameter int         SCREEN_WIDTH   = 76,
    parameter int         SCREEN_HEIGHT  = 44,
    parameter logic [7:0] BLANK_CHAR     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter int         BLINK_FRAMES   = 30
) (
    input logic                         clk_in,
    input logic                         rst_n_in,
    terminal_scroll_controller_if.slave bus
);
    localparam int W     = SCREEN_WIDTH;
    localparam int H     = SCREEN_HEIGHT;
    localparam int CELLS = W * H;
    localparam int AW    = $clog2(CELLS);
    localparam int CW    = $clog2(W);
    localparam int RW    = $clog2(H);
    localparam int BW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [RW:0] H_EXT = (RW+1)'(H);

    typedef enum logic [1:0] {S_CLEAR_ALL, S_IDLE, S_CLEAR_ROW} state_t;

    state_t        state_q;
    logic [CW-1:0] col_q, clr_col_q;
    logic [RW-1:0] row_q, scroll_q;
    logic [AW-1:0] clr_addr_q, addr_q;
    logic [7:0]    data_q;
    logic          we_q, cursor_on_q;
    logic [BW-1:0] blink_q;

    logic          ready, acc_enter, acc_bksp, acc_char, accepted;
    logic          at_last_col, at_last_row, do_scroll;
    logic [RW-1:0] scroll_d;

    // Logical-to-physical row mapping: one conditional subtract replaces the modulo.
    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lrow, input logic [RW-1:0] scroll);
        logic [RW:0] sum;
        sum = {1'b0, lrow} + {1'b0, scroll};
        if (sum >= H_EXT) sum = sum - H_EXT;
        return sum[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] prow, input logic [CW-1:0] col);
        return AW'(prow) * AW'(W) + AW'(col);
    endfunction

    assign ready       = (state_q == S_IDLE);
    assign acc_enter   = ready & bus.enter_in;
    assign acc_bksp    = ready & ~bus.enter_in & bus.bksp_in;
    assign acc_char    = ready & ~bus.enter_in & ~bus.bksp_in & bus.char_valid_in;
    assign accepted    = acc_enter | acc_bksp | acc_char;
    assign at_last_col = (col_q == CW'(W - 1));
    assign at_last_row = (row_q == RW'(H - 1));
    assign do_scroll   = (acc_enter | (acc_char & at_last_col)) & at_last_row;
    assign scroll_d    = (scroll_q == RW'(H - 1)) ? '0 : scroll_q + 1'b1;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= CLEAR_ON_RESET ? S_CLEAR_ALL : S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            scroll_q    <= '0;
            clr_col_q   <= '0;
            clr_addr_q  <= '0;
            addr_q      <= '0;
            data_q      <= BLANK_CHAR;
            we_q        <= 1'b0;
            cursor_on_q <= 1'b1;
            blink_q     <= '0;
        end else begin
            we_q <= 1'b0;

            if (accepted) begin
                cursor_on_q <= 1'b1;
                blink_q     <= '0;
            end else if (bus.new_frame_in) begin
                if (blink_q == BW'(BLINK_FRAMES - 1)) begin
                    cursor_on_q <= ~cursor_on_q;
                    blink_q     <= '0;
                end else begin
                    blink_q <= blink_q + 1'b1;
                end
            end

            case (state_q)
                S_CLEAR_ALL: begin
                    we_q       <= 1'b1;
                    addr_q     <= clr_addr_q;
                    data_q     <= BLANK_CHAR;
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == AW'(CELLS - 1)) state_q <= S_IDLE;
                end
                S_CLEAR_ROW: begin
                    we_q       <= 1'b1;
                    addr_q     <= clr_addr_q;
                    data_q     <= BLANK_CHAR;
                    clr_addr_q <= clr_addr_q + 1'b1;
                    clr_col_q  <= clr_col_q + 1'b1;
                    if (clr_col_q == CW'(W - 1)) state_q <= S_IDLE;
                end
                S_IDLE: begin
                    if (acc_enter) begin
                        col_q <= '0;
                        if (!at_last_row) row_q <= row_q + 1'b1;
                    end else if (acc_bksp) begin
                        if (col_q != '0) begin
                            col_q  <= col_q - 1'b1;
                            we_q   <= 1'b1;
                            addr_q <= cell_addr(phys_row(row_q, scroll_q), col_q - 1'b1);
                            data_q <= BLANK_CHAR;
                        end else if (row_q != '0) begin
                            row_q  <= row_q - 1'b1;
                            col_q  <= CW'(W - 1);
                            we_q   <= 1'b1;
                            addr_q <= cell_addr(phys_row(row_q - 1'b1, scroll_q), CW'(W - 1));
                            data_q <= BLANK_CHAR;
                        end
                    end else if (acc_char) begin
                        we_q   <= 1'b1;
                        addr_q <= cell_addr(phys_row(row_q, scroll_q), col_q);
                        data_q <= bus.char_in;
                        if (!at_last_col) begin
                            col_q <= col_q + 1'b1;
                        end else begin
                            col_q <= '0;
                            if (!at_last_row) row_q <= row_q + 1'b1;
                        end
                    end
                    // The row leaving the top becomes the new bottom row and is blanked.
                    if (do_scroll) begin
                        state_q    <= S_CLEAR_ROW;
                        scroll_q   <= scroll_d;
                        clr_addr_q <= cell_addr(scroll_q, '0);
                        clr_col_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready_out      = ready;
    assign bus.tg_we          = we_q;
    assign bus.tg_addr        = addr_q;
    assign bus.tg_input       = data_q;
    assign bus.cursor_col_out = col_q;
    assign bus.cursor_row_out = row_q;
    assign bus.scroll_row_out = scroll_q;
    assign bus.cursor_on_out  = cursor_on_q;
endmodule

// File: tb/tb_terminal_scroll_controller.sv
// Bench for terminal_scroll_controller: directed scenarios plus random traffic,
// all cycles compared against a queue-based reference of the write stream.
module tb_terminal_scroll_controller;
    localparam int         W     = 76;
    localparam int         H     = 44;
    localparam int         N     = W * H;
    localparam int         BF    = 2;
    localparam logic [7:0] BLANK = 8'h20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    terminal_scroll_controller_if #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) bus();

    terminal_scroll_controller #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .BLANK_CHAR(BLANK),
        .CLEAR_ON_RESET(1'b1), .BLINK_FRAMES(BF)
    ) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: pending grid writes (addr*256+data, -1 = idle cycle), cursor, blink.
    int wq[$];
    int exp_w;
    int m_col, m_row, m_scroll, m_bc;
    bit m_on;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int m_addr(input int r, input int c);
        return ((r + m_scroll) % H) * W + c;
    endfunction

    task automatic model_reset();
        wq.delete();
        for (int i = 0; i < N; i++) wq.push_back(i * 256 + BLANK);
        m_col = 0; m_row = 0; m_scroll = 0; m_bc = 0; m_on = 1'b1; exp_w = -1;
    endtask

    task automatic model_scroll(input bit gap);
        int old;
        if (gap) wq.push_back(-1);
        old = m_scroll;
        m_scroll = (m_scroll + 1) % H;
        for (int c = 0; c < W; c++) wq.push_back((old * W + c) * 256 + BLANK);
    endtask

    task automatic model_edge();
        bit rdy, acc;
        rdy = (wq.size() == 0);
        acc = rdy && (bus.enter_in || bus.bksp_in || bus.char_valid_in);
        if (acc) begin
            m_on = 1'b1; m_bc = 0;
        end else if (bus.new_frame_in) begin
            m_bc++;
            if (m_bc == BF) begin m_on = !m_on; m_bc = 0; end
        end
        if (acc) begin
            if (bus.enter_in) begin
                m_col = 0;
                if (m_row < H - 1) m_row++; else model_scroll(1'b1);
            end else if (bus.bksp_in) begin
                if (m_col > 0) begin
                    m_col--; wq.push_back(m_addr(m_row, m_col) * 256 + BLANK);
                end else if (m_row > 0) begin
                    m_row--; m_col = W - 1; wq.push_back(m_addr(m_row, m_col) * 256 + BLANK);
                end
            end else begin
                wq.push_back(m_addr(m_row, m_col) * 256 + int'(bus.char_in));
                if (m_col < W - 1) m_col++;
                else begin
                    m_col = 0;
                    if (m_row < H - 1) m_row++; else model_scroll(1'b0);
                end
            end
        end
        exp_w = (wq.size() > 0) ? wq.pop_front() : -1;
    endtask

    task automatic compare_all();
        chk("we", int'(bus.tg_we), int'(exp_w >= 0));
        if (exp_w >= 0 && bus.tg_we) begin
            chk("addr", int'(bus.tg_addr), exp_w / 256);
            chk("data", int'(bus.tg_input), exp_w % 256);
        end
        chk("ready", int'(bus.ready_out), int'(wq.size() == 0));
        chk("col", int'(bus.cursor_col_out), m_col);
        chk("row", int'(bus.cursor_row_out), m_row);
        chk("scroll", int'(bus.scroll_row_out), m_scroll);
        chk("cursor_on", int'(bus.cursor_on_out), int'(m_on));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit e, input bit b, input bit c, input logic [7:0] d, input bit f);
        bus.enter_in = e; bus.bksp_in = b; bus.char_valid_in = c; bus.char_in = d; bus.new_frame_in = f;
        cyc();
        bus.enter_in = 0; bus.bksp_in = 0; bus.char_valid_in = 0; bus.char_in = 8'h00; bus.new_frame_in = 0;
    endtask

    task automatic run_clear();
        int cnt = 0;
        int last = -1;
        for (int i = 0; i < N + 20 && !bus.ready_out; i++) begin
            cyc();
            if (bus.tg_we) begin cnt++; last = int'(bus.tg_addr); end
        end
        chk("clear_all_writes", cnt, N);
        chk("clear_all_last_addr", last, N - 1);
        chk("clear_all_ready", int'(bus.ready_out), 1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && !bus.ready_out; i++) cyc();
        chk("ready_wait", int'(bus.ready_out), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        compare_all();
        chk({tag, "_we"}, int'(bus.tg_we), 0);
        chk({tag, "_addr"}, int'(bus.tg_addr), 0);
        chk({tag, "_data"}, int'(bus.tg_input), int'(BLANK));
        chk({tag, "_pos"}, int'(bus.cursor_row_out) * 256 + int'(bus.cursor_col_out), 0);
        chk({tag, "_scroll"}, int'(bus.scroll_row_out), 0);
        chk({tag, "_on"}, int'(bus.cursor_on_out), 1);
        chk({tag, "_ready"}, int'(bus.ready_out), 0);
    endtask

    initial begin
        bus.enter_in = 0; bus.bksp_in = 0; bus.char_valid_in = 0; bus.char_in = 8'h00; bus.new_frame_in = 0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        run_clear();

        // First character lands at the top-left cell one cycle after acceptance.
        drive(0, 0, 1, 8'h41, 0);
        chk("charA_we", int'(bus.tg_we), 1);
        chk("charA_addr", int'(bus.tg_addr), 0);
        chk("charA_data", int'(bus.tg_input), 8'h41);
        chk("charA_col", int'(bus.cursor_col_out), 1);
        drive(0, 1, 0, 8'h00, 0);

        // Full row from (5,0) wraps to (6,0) without scrolling.
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < W; i++) drive(0, 0, 1, 8'(33 + i), 0);
        chk("wrap_last_addr", int'(bus.tg_addr), 455);
        chk("wrap_row", int'(bus.cursor_row_out), 6);
        chk("wrap_col", int'(bus.cursor_col_out), 0);
        chk("wrap_scroll", int'(bus.scroll_row_out), 0);

        // Enter on the bottom row scrolls; characters during the row clear are dropped.
        for (int i = 0; i < 37; i++) drive(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 1, 8'h5A, 0);
        drive(1, 0, 0, 8'h00, 0);
        chk("scroll1_scroll", int'(bus.scroll_row_out), 1);
        chk("scroll1_pos", int'(bus.cursor_row_out) * 256 + int'(bus.cursor_col_out), 43 * 256);
        chk("scroll1_we", int'(bus.tg_we), 0);
        for (int i = 0; i < W; i++) begin
            drive(0, 0, 1, 8'h58, 0);
            if (i == 0) chk("clrrow_first_addr", int'(bus.tg_addr), 0);
            if (i == W - 1) chk("clrrow_last_addr", int'(bus.tg_addr), 75);
        end
        chk("clrrow_ready_back", int'(bus.ready_out), 1);
        chk("clrrow_col_kept", int'(bus.cursor_col_out), 0);

        drive(1, 0, 0, 8'h00, 0); wait_ready();
        drive(1, 0, 0, 8'h00, 0); wait_ready();
        chk("scroll3", int'(bus.scroll_row_out), 3);

        // Backspace all the way to the top-left, then probe the boundary cases.
        for (int i = 0; i < 4000 && !(m_row == 0 && m_col == 0); i++) drive(0, 1, 0, 8'h00, 0);
        drive(0, 1, 0, 8'h00, 0);
        chk("bksp_origin_we", int'(bus.tg_we), 0);
        drive(1, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        drive(0, 1, 0, 8'h00, 0);
        chk("bksp_wrap_addr", int'(bus.tg_addr), 379);
        chk("bksp_wrap_pos", int'(bus.cursor_row_out) * 256 + int'(bus.cursor_col_out), 1 * 256 + 75);
        for (int i = 0; i < 71; i++) drive(0, 1, 0, 8'h00, 0);
        chk("at_1_4", int'(bus.cursor_row_out) * 256 + int'(bus.cursor_col_out), 1 * 256 + 4);
        drive(1, 1, 1, 8'h51, 0);
        chk("prio_pos", int'(bus.cursor_row_out) * 256 + int'(bus.cursor_col_out), 2 * 256);
        chk("prio_we", int'(bus.tg_we), 0);

        // Blink phase with a two-frame half-period.
        drive(0, 0, 0, 8'h00, 1); drive(0, 0, 0, 8'h00, 1);
        chk("blink_off", int'(bus.cursor_on_out), 0);
        drive(0, 0, 0, 8'h00, 1); drive(0, 0, 0, 8'h00, 1);
        chk("blink_on", int'(bus.cursor_on_out), 1);
        drive(0, 0, 0, 8'h00, 1); drive(0, 0, 0, 8'h00, 1);
        drive(0, 0, 1, 8'h42, 0);
        chk("blink_forced", int'(bus.cursor_on_out), 1);
        drive(0, 0, 0, 8'h00, 1);
        chk("blink_count_reset", int'(bus.cursor_on_out), 1);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                  8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
        end

        // Reset in the middle of a row clear.
        wait_ready();
        for (int i = 0; i < H + 2; i++) begin
            drive(1, 0, 0, 8'h00, 0);
            if (!bus.ready_out) break;
        end
        chk("midclr_busy", int'(bus.ready_out), 0);
        for (int i = 0; i < 5; i++) cyc();
        rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("midclr_reset");
        @(posedge clk); #1 rst_n = 1'b1;
        run_clear();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0,
                  8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
